// File: rtl/gray_tp_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : gray_tp_sequencer
// Description : Chase test-pattern scheduler for one codeword. A binary
//               pattern counter is converted to a GC_LEN-bit Gray code. Each
//               issued pattern carries a registered one-hot select telling the
//               datapath which LRP bit flipped relative to the previous
//               pattern (sel[0] = reuse previous, sel[k+1] = toggle bit k).
//               Optional feature macro: GRAY_TP_EARLY_TERM_EN adds an
//               i_early_term input that ends the sequence on any accept.
// Revision    : 1.0 - initial release
// ============================================================================
module gray_tp_sequencer #(
    parameter int GC_LEN     = 2,
    parameter int SEL_LENGTH = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_start,
    input  logic [GC_LEN:0]       i_num_tp,
    output logic                  o_ready,
    output logic                  o_tp_valid,
    input  logic                  i_tp_ready,
`ifdef GRAY_TP_EARLY_TERM_EN
    input  logic                  i_early_term,
`endif
    output logic [GC_LEN-1:0]     o_gc,
    output logic [SEL_LENGTH-1:0] o_sel_TP,
    output logic                  o_last,
    output logic                  o_done
);

    // Largest pattern count and the matching last counter index.
    localparam logic [GC_LEN:0]     MAX_TP   = (GC_LEN+1)'(1) << GC_LEN;
    localparam logic [GC_LEN-1:0]   MAX_IDX  = {GC_LEN{1'b1}};
    localparam logic [SEL_LENGTH-1:0] SEL_REUSE = SEL_LENGTH'(1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [GC_LEN-1:0]       b_q, b_d;
    logic [GC_LEN-1:0]       last_idx_q, last_idx_d;
    logic [GC_LEN-1:0]       gc_q, gc_d;
    logic [SEL_LENGTH-1:0]   sel_q, sel_d;
    logic                    valid_q, valid_d;
    logic                    last_q, last_d;
    logic                    done_q, done_d;
    logic                    ready_q, ready_d;

    logic [GC_LEN:0]         w_num_m1;
    logic [GC_LEN-1:0]       w_start_last_idx;
    logic [GC_LEN-1:0]       w_b_inc;
    logic [GC_LEN-1:0]       w_gc_inc;
    logic [GC_LEN:0]         w_flip_sel;
    logic                    w_accept;
    logic                    w_end_seq;

    function automatic logic [GC_LEN-1:0] to_gray(input logic [GC_LEN-1:0] bin);
        return bin ^ (bin >> 1);
    endfunction

    // Clamp the requested count into a last-index: 0 or over-range means all patterns.
    always_comb begin
        w_num_m1 = i_num_tp - (GC_LEN+1)'(1);
        if ((i_num_tp == '0) || (i_num_tp > MAX_TP)) begin
            w_start_last_idx = MAX_IDX;
        end else begin
            w_start_last_idx = w_num_m1[GC_LEN-1:0];
        end
    end

    // Next pattern's Gray code and the single flipped bit shifted past the reuse slot.
    always_comb begin
        w_b_inc    = b_q + GC_LEN'(1);
        w_gc_inc   = to_gray(w_b_inc);
        w_flip_sel = {w_gc_inc ^ gc_q, 1'b0};
        w_accept   = valid_q & i_tp_ready;
`ifdef GRAY_TP_EARLY_TERM_EN
        w_end_seq  = last_q | i_early_term;
`else
        w_end_seq  = last_q;
`endif
    end

    // Next-state and registered-output computation; everything holds by default.
    always_comb begin
        state_d    = state_q;
        b_d        = b_q;
        last_idx_d = last_idx_q;
        gc_d       = gc_q;
        sel_d      = sel_q;
        valid_d    = valid_q;
        last_d     = last_q;
        done_d     = 1'b0;
        ready_d    = ready_q;

        case (state_q)
            ST_IDLE: begin
                ready_d = 1'b1;
                valid_d = 1'b0;
                if (i_start) begin
                    state_d    = ST_ISSUE;
                    last_idx_d = w_start_last_idx;
                    b_d        = '0;
                    gc_d       = '0;
                    sel_d      = SEL_REUSE;
                    valid_d    = 1'b1;
                    last_d     = (w_start_last_idx == '0);
                    ready_d    = 1'b0;
                end
            end

            ST_ISSUE: begin
                // Without an accept the pattern stays put (stall).
                if (w_accept) begin
                    if (w_end_seq) begin
                        state_d = ST_DONE;
                        valid_d = 1'b0;
                        last_d  = 1'b0;
                        done_d  = 1'b1;
                        b_d     = '0;
                        gc_d    = '0;
                        sel_d   = SEL_REUSE;
                    end else begin
                        b_d    = w_b_inc;
                        gc_d   = w_gc_inc;
                        sel_d  = SEL_LENGTH'(w_flip_sel);
                        last_d = (w_b_inc == last_idx_q);
                    end
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
                ready_d = 1'b1;
            end

            default: begin
                state_d = ST_IDLE;
                ready_d = 1'b1;
                valid_d = 1'b0;
                last_d  = 1'b0;
                b_d     = '0;
                gc_d    = '0;
                sel_d   = SEL_REUSE;
            end
        endcase
    end

    // State and output registers with asynchronous reset to the idle values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            b_q        <= '0;
            last_idx_q <= '0;
            gc_q       <= '0;
            sel_q      <= SEL_REUSE;
            valid_q    <= 1'b0;
            last_q     <= 1'b0;
            done_q     <= 1'b0;
            ready_q    <= 1'b1;
        end else begin
            state_q    <= state_d;
            b_q        <= b_d;
            last_idx_q <= last_idx_d;
            gc_q       <= gc_d;
            sel_q      <= sel_d;
            valid_q    <= valid_d;
            last_q     <= last_d;
            done_q     <= done_d;
            ready_q    <= ready_d;
        end
    end

    // Ports are driven straight from flops.
    always_comb begin
        o_ready    = ready_q;
        o_tp_valid = valid_q;
        o_gc       = gc_q;
        o_sel_TP   = sel_q;
        o_last     = last_q;
        o_done     = done_q;
    end

endmodule
`default_nettype wire
